// File: rtl/ex_muldiv.sv
// ex_muldiv: MIPS execute stage. Logic, add/sub and compares are combinational;
// multiply and divide run iteratively over DATA_W cycles, stall the pipeline and
// write the HI/LO registers. The divider is built only when EX_DIV_EN is defined;
// otherwise DIV/DIVU behave as NOP.
module ex_muldiv #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              ov_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpAdd  = 4'd3;
  localparam logic [3:0] OpSub  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSltu = 4'd6;
  localparam logic [3:0] OpMult = 4'd7;
  localparam logic [3:0] OpMulu = 4'd8;
  localparam logic [3:0] OpDiv  = 4'd9;
  localparam logic [3:0] OpDivu = 4'd10;
  localparam logic [3:0] OpMfhi = 4'd11;
  localparam logic [3:0] OpMflo = 4'd12;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  // acc: partial product upper half / partial remainder
  // sh:  multiplier shifting out / dividend shifting out, quotient shifting in
  // m:   multiplicand / divisor
  logic [DATA_W-1:0] acc_q, acc_d, sh_q, sh_d, m_q, m_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              neg_q, neg_d;
`ifdef EX_DIV_EN
  logic              div_q, div_d, rneg_q, rneg_d;
  logic [DATA_W:0]   rem_sh, rem_diff;
`endif

  logic              is_mul, is_div, is_md, op_signed;
  logic              is_sub, add_ov, slt, sltu;
  logic [DATA_W-1:0] b_eff, sum, a_abs, b_abs;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] step_acc, step_sh, res_hi, res_lo;
  logic [2*DATA_W-1:0] prod_mag, prod;

  // Opcode decode for the iterative unit.
  always_comb begin
    is_mul    = (aluop_i == OpMult) || (aluop_i == OpMulu);
`ifdef EX_DIV_EN
    is_div    = (aluop_i == OpDiv) || (aluop_i == OpDivu);
`else
    is_div    = 1'b0;
`endif
    is_md     = is_mul || is_div;
    op_signed = (aluop_i == OpMult) || (aluop_i == OpDiv);
    a_abs     = (op_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    b_abs     = (op_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
  end

  // Adder shared by ADD/SUB, plus the two compares.
  always_comb begin
    is_sub = (aluop_i == OpSub);
    b_eff  = is_sub ? ~reg2_i : reg2_i;
    sum    = reg1_i + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
    add_ov = (reg1_i[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
    slt    = $signed(reg1_i) < $signed(reg2_i);
    sltu   = reg1_i < reg2_i;
  end

  // GPR write-back outputs; everything forced low while in reset.
  always_comb begin
    wdata_o = '0;
    wreg_o  = 1'b0;
    ov_o    = 1'b0;
    case (aluop_i)
      OpOr:   begin wdata_o = reg1_i | reg2_i; wreg_o = wreg_i; end
      OpAnd:  begin wdata_o = reg1_i & reg2_i; wreg_o = wreg_i; end
      OpAdd, OpSub: begin
        wdata_o = sum;
        ov_o    = add_ov;
        wreg_o  = wreg_i & ~add_ov;
      end
      OpSlt:  begin wdata_o = {{(DATA_W-1){1'b0}}, slt};  wreg_o = wreg_i; end
      OpSltu: begin wdata_o = {{(DATA_W-1){1'b0}}, sltu}; wreg_o = wreg_i; end
      OpMfhi: begin wdata_o = hi_q; wreg_o = wreg_i; end
      OpMflo: begin wdata_o = lo_q; wreg_o = wreg_i; end
      OpMult, OpMulu, OpDiv, OpDivu: begin end
      default: begin end
    endcase
    wd_o = wd_i;
    if (rst) begin
      wdata_o = '0;
      wreg_o  = 1'b0;
      ov_o    = 1'b0;
      wd_o    = '0;
    end
  end

  // Stall while issuing (and not being flushed) and across every BUSY step.
  always_comb begin
    stall_o = !rst && (((state_q == StIdle) && is_md && !flush_i) || (state_q == StBusy));
  end

  // One radix-2 step and the signed fixup of the final result.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, m_q & {DATA_W{sh_q[0]}}};
    step_acc = mul_sum[DATA_W:1];
    step_sh  = {mul_sum[0], sh_q[DATA_W-1:1]};
    prod_mag = {acc_q, sh_q};
    prod     = neg_q ? -prod_mag : prod_mag;
    res_hi   = prod[2*DATA_W-1:DATA_W];
    res_lo   = prod[DATA_W-1:0];
`ifdef EX_DIV_EN
    rem_sh   = {acc_q, sh_q[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, m_q};
    if (div_q) begin
      // Restoring division: a set borrow bit means the trial subtraction failed.
      if (!rem_diff[DATA_W]) begin
        step_acc = rem_diff[DATA_W-1:0];
        step_sh  = {sh_q[DATA_W-2:0], 1'b1};
      end else begin
        step_acc = rem_sh[DATA_W-1:0];
        step_sh  = {sh_q[DATA_W-2:0], 1'b0};
      end
      // Divide by zero: all-ones quotient; remainder restores the original dividend.
      res_lo = (m_q == '0) ? '1 : (neg_q ? -sh_q : sh_q);
      res_hi = rneg_q ? -acc_q : acc_q;
    end
`endif
  end

  // Next-state logic for the mul/div sequencer and HI/LO.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    m_d     = m_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef EX_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      StIdle: begin
        if (is_md) begin
          state_d = StBusy;
          count_d = '0;
          acc_d   = '0;
          sh_d    = is_div ? a_abs : b_abs;
          m_d     = is_div ? b_abs : a_abs;
          neg_d   = op_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
`ifdef EX_DIV_EN
          div_d   = is_div;
          rneg_d  = op_signed && reg1_i[DATA_W-1];
`endif
        end
      end
      StBusy: begin
        acc_d   = step_acc;
        sh_d    = step_sh;
        count_d = count_q + CNT_W'(1);
        if (count_q == LastStep) begin
          state_d = StDone;
        end
      end
      StDone: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush abandons the operation without touching HI/LO, even from DONE.
    if (flush_i) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef EX_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef EX_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv (DATA_W = 32). A reference model
// built on 64-bit arithmetic predicts each op; a monitor compares whenever the
// pipeline advances (stall_o low while an op is presented).
`timescale 1ns/1ps
module tb_ex_muldiv;

`ifdef EX_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wreg, flush;
  logic [3:0]  aluop;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic [4:0]  wd_o;
  logic        wreg_o, ov_o, stall_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  ex_muldiv #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .aluop_i (aluop),
    .reg1_i  (reg1),
    .reg2_i  (reg2),
    .wd_i    (wd),
    .wreg_i  (wreg),
    .flush_i (flush),
    .wd_o    (wd_o),
    .wreg_o  (wreg_o),
    .wdata_o (wdata_o),
    .ov_o    (ov_o),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] data;
    logic        ov;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          live = 1'b0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: MIPS semantics from plain 64-bit arithmetic; updates m_hi/m_lo.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr, output logic wr_e, output logic [31:0] d_e,
                       output logic ov_e, output bit md);
    longint          sa, sb_, s;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a); sb_ = $signed(b); ua = a; ub = b;
    wr_e = 1'b0; d_e = '0; ov_e = 1'b0; md = 1'b0;
    case (op)
      4'd1: begin d_e = a | b; wr_e = wr; end
      4'd2: begin d_e = a & b; wr_e = wr; end
      4'd3, 4'd4: begin
        s    = (op == 4'd3) ? sa + sb_ : sa - sb_;
        d_e  = s[31:0];
        ov_e = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        wr_e = wr && !ov_e;
      end
      4'd5: begin d_e = (sa < sb_) ? 32'd1 : 32'd0; wr_e = wr; end
      4'd6: begin d_e = (ua < ub) ? 32'd1 : 32'd0; wr_e = wr; end
      4'd7: begin p = sa * sb_; m_hi = p[63:32]; m_lo = p[31:0]; md = 1'b1; end
      4'd8: begin p = ua * ub;  m_hi = p[63:32]; m_lo = p[31:0]; md = 1'b1; end
      4'd9: if (DivEn) begin
        md = 1'b1;
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin
          s = sa / sb_; m_lo = s[31:0];
          s = sa % sb_; m_hi = s[31:0];
        end
      end
      4'd10: if (DivEn) begin
        md = 1'b1;
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
        end
      end
      4'd11: begin d_e = m_hi; wr_e = wr; end
      4'd12: begin d_e = m_lo; wr_e = wr; end
      default: begin end
    endcase
  endtask

  // Present one op, push its expectation, and hold it until the pipeline advances.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr);
    exp_t        e;
    bit          md;
    int          stalls;
    logic        wr_e, ov_e;
    logic [31:0] d_e;
    e.wd = 5'($urandom);
    e.hi = m_hi;
    e.lo = m_lo;
    model(op, a, b, wr, wr_e, d_e, ov_e, md);
    e.wr = wr_e; e.data = d_e; e.ov = ov_e;
    sb.push_back(e);
    aluop = op; reg1 = a; reg2 = b; wreg = wr; wd = e.wd; live = 1'b1;
    stalls = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall_o) break;
      stalls++;
    end
    chk("stall_cycles", 64'(stalls), md ? 64'd33 : 64'd0);
    @(posedge clk); #1;
    live  = 1'b0;
    aluop = 4'd0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one scoreboard entry retires each cycle the DUT lets the op advance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (live && !rst && !stall_o) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("wd_o", 64'(wd_o), 64'(e.wd));
          chk("wreg_o", 64'(wreg_o), 64'(e.wr));
          chk("wdata_o", 64'(wdata_o), 64'(e.data));
          chk("ov_o", 64'(ov_o), 64'(e.ov));
          chk("hi_o", 64'(hi_o), 64'(e.hi));
          chk("lo_o", 64'(lo_o), 64'(e.lo));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; aluop = 4'd1; reg1 = 32'hF0; reg2 = 32'h0F; wreg = 1'b1;
    wd = 5'd9; m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("rst_wreg", 64'(wreg_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    chk("rst_wd", 64'(wd_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_ov", 64'(ov_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop = 4'd0;
    @(negedge clk);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    @(posedge clk); #1;

    // Directed cases
    issue(4'd3, 32'h7FFF_FFFF, 32'h1, 1'b1);
    issue(4'd4, 32'd5, 32'd7, 1'b1);
    issue(4'd5, 32'hFFFF_FFFF, 32'h1, 1'b1);
    issue(4'd6, 32'hFFFF_FFFF, 32'h1, 1'b1);
    issue(4'd1, 32'hF0, 32'h0F, 1'b1);
    issue(4'd7, 32'hFFFF_FFFD, 32'd5, 1'b0);
    issue(4'd12, 32'd0, 32'd0, 1'b1);
    issue(4'd9, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(4'd11, 32'd0, 32'd0, 1'b1);
    issue(4'd12, 32'd0, 32'd0, 1'b1);
    issue(4'd10, 32'd7, 32'd0, 1'b0);
    issue(4'd11, 32'd0, 32'd0, 1'b1);
    issue(4'd12, 32'd0, 32'd0, 1'b1);

    // Preload HI=1/LO=2, then flush a MULTU at BUSY count 10
    issue(4'd8, 32'h8000_0001, 32'd2, 1'b0);
    aluop = 4'd8; reg1 = 32'd3; reg2 = 32'd3; wreg = 1'b0;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1; aluop = 4'd0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 64'(stall_o), 64'd0);
    chk("flush_hi", 64'(hi_o), 64'd1);
    chk("flush_lo", 64'(lo_o), 64'd2);
    @(posedge clk); #1;
    issue(4'd8, 32'd3, 32'd3, 1'b0);
    issue(4'd12, 32'd0, 32'd0, 1'b1);

    // Reset in the middle of a BUSY sequence
    aluop = 4'd7; reg1 = 32'h1234_5678; reg2 = 32'h9ABC_DEF0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; aluop = 4'd1; reg1 = 32'hF0; reg2 = 32'h0F; wreg = 1'b1; wd = 5'd3;
    @(negedge clk);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_wreg", 64'(wreg_o), 64'd0);
    chk("midrst_wdata", 64'(wdata_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0; aluop = 4'd0;
    @(negedge clk);
    chk("postrst_stall", 64'(stall_o), 64'd0);
    chk("postrst_hi", 64'(hi_o), 64'd0);
    chk("postrst_lo", 64'(lo_o), 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;

    // Randomized ops
    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1'($urandom));
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
